// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its consumers: opcode mnemonics,
// fetch FSM states, the halt word and the default datapath widths.
package fetch_unit_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int INST_W_DEF = 9;
    localparam int LUT_W_DEF  = 4;

    typedef enum logic [2:0] {
        LDR = 3'b000,
        STR = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        ADD = 3'b100,
        SUB = 3'b101,
        BEQ = 3'b110,
        MOV = 3'b111
    } op_mne;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_e;

    // MOV with an all-ones operand terminates the program.
    localparam logic [INST_W_DEF-1:0] HALT_WORD = 9'h1FF;

    function automatic op_mne decode_op(input logic [INST_W_DEF-1:0] inst);
        return op_mne'(inst[INST_W_DEF-1 -: 3]);
    endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target lookup: maps the low operand bits of a BEQ to an absolute PC.
// Retarget programs by editing the case table; the fetch FSM is untouched.
module branch_lut #(
    parameter int LUT_W = 4,
    parameter int PC_W  = 10
) (
    input  logic [LUT_W-1:0] idx,
    output logic [PC_W-1:0]  target
);

    always_comb begin
        // NOTE: a default before the case keeps this purely combinational (no latch).
        target = '0;
        case (idx)
            LUT_W'(0): target = PC_W'(40);
            LUT_W'(1): target = PC_W'(64);
            LUT_W'(2): target = PC_W'(100);
            LUT_W'(3): target = PC_W'(20);
            LUT_W'(4): target = PC_W'(200);
            LUT_W'(5): target = PC_W'(512);
            LUT_W'(6): target = PC_W'(1000);
            LUT_W'(7): target = PC_W'(1023);
            default:   target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, instruction register, BEQ
// redirect through branch_lut and the Start/Done program handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int LUT_W  = LUT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [INST_W-1:0] InstIn,
    output logic [PC_W-1:0]   InstAddr,
    output logic [INST_W-1:0] InstOut,
    output logic [2:0]        Op,
    output logic              Valid,
    output logic              Done
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   branch_target;
    logic              is_halt;
    logic              is_redirect;

    branch_lut #(
        .LUT_W (LUT_W),
        .PC_W  (PC_W)
    ) u_branch_lut (
        .idx    (ir_q[LUT_W-1:0]),
        .target (branch_target)
    );

    // Halt and redirect are judged on the registered instruction only.
    assign is_halt     = valid_q && (ir_q == INST_W'(HALT_WORD));
    assign is_redirect = valid_q && (ir_q[INST_W-1 -: 3] == BEQ) && BranchTaken;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (!Stall) begin
            case (state_q)
                IDLE: begin
                    pc_d = '0;
                    if (Start) state_d = RUN;
                end
                RUN: begin
                    if (is_halt) begin
                        state_d = HALT;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (is_redirect) begin
                        // Squash the wrong-path word fetched alongside the redirect.
                        pc_d    = branch_target;
                        ir_d    = '0;
                        valid_d = 1'b0;
                    end else begin
                        ir_d    = InstIn;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end
                HALT: begin
                    if (Start) begin
                        state_d = RUN;
                        pc_d    = '0;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign InstAddr = pc_q;
    assign InstOut  = ir_q;
    assign Op       = ir_q[INST_W-1 -: 3];
    assign Valid    = valid_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stimulus compared against a behavioural program-execution model.
module tb_fetch_unit;

    localparam int PC_W   = 10;
    localparam int INST_W = 9;
    localparam int DEPTH  = 1 << PC_W;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic              Stall;
    logic              BranchTaken;
    logic [INST_W-1:0] InstIn;
    logic [PC_W-1:0]   InstAddr;
    logic [INST_W-1:0] InstOut;
    logic [2:0]        Op;
    logic              Valid;
    logic              Done;

    logic [INST_W-1:0] rom [DEPTH];
    int                lut_tgt [16];

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=idle, 1=running, 2=halted.
    int                m_mode;
    int                m_pc;
    logic [INST_W-1:0] m_ir;
    bit                m_valid;
    bit                m_done;

    fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .LUT_W(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .InstIn      (InstIn),
        .InstAddr    (InstAddr),
        .InstOut     (InstOut),
        .Op          (Op),
        .Valid       (Valid),
        .Done        (Done)
    );

    assign InstIn = rom[InstAddr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic m_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_ir    = '0;
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    // One program step as the programmer sees it.
    task automatic m_step();
        if (Stall) return;
        if (m_mode == 0) begin
            m_pc = 0;
            if (Start) m_mode = 1;
        end else if (m_mode == 2) begin
            if (Start) begin
                m_mode = 1;
                m_pc   = 0;
                m_done = 1'b0;
            end
        end else if (m_valid && m_ir == 9'h1FF) begin
            m_mode  = 2;
            m_done  = 1'b1;
            m_valid = 1'b0;
        end else if (m_valid && m_ir[8:6] == 3'd6 && BranchTaken) begin
            m_pc    = lut_tgt[m_ir[3:0]];
            m_ir    = '0;
            m_valid = 1'b0;
        end else begin
            m_ir    = rom[m_pc];
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % DEPTH;
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_rom_add();
        for (int i = 0; i < DEPTH; i++) rom[i] = {3'b100, 6'(i)};
    endtask

    task automatic do_reset();
        Start       = 1'b0;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        m_reset();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_run();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        fill_rom_add();
        do_reset();
        start_run();
        for (int i = 0; i < 37; i++) tick();
        checks++;
        if (InstAddr !== 10'd37) begin
            errors++;
            $display("FAIL reset_pre_pc: got %0d expected 37", InstAddr);
        end
        #2;
        Reset = 1'b0;
        #1;
        m_reset();
        checks++;
        if (InstAddr !== '0 || Valid !== 1'b0 || Done !== 1'b0 || InstOut !== '0) begin
            errors++;
            $display("FAIL reset_async: pc=%0d valid=%b done=%b ir=%h expected 0/0/0/000",
                     InstAddr, Valid, Done, InstOut);
        end
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (InstAddr !== '0 || Valid !== 1'b0 || Done !== 1'b0 || Op !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle_hold: pc=%0d valid=%b done=%b op=%0d expected 0/0/0/0",
                         InstAddr, Valid, Done, Op);
            end
        end
    endtask

    task automatic test_sequential();
        logic [INST_W-1:0] exp_ir [3];
        logic [2:0]        exp_op [3];
        exp_ir = '{9'h100, 9'h0C5, 9'h085};
        exp_op = '{3'd4, 3'd3, 3'd2};
        fill_rom_add();
        rom[0] = 9'h100; rom[1] = 9'h0C5; rom[2] = 9'h085; rom[3] = 9'h1FF;
        do_reset();
        start_run();
        checks++;
        if (InstAddr !== '0 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_first_addr: pc=%0d valid=%b expected 0/0", InstAddr, Valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (InstOut !== exp_ir[i] || Op !== exp_op[i] || Valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: ir=%h op=%0d valid=%b expected %h/%0d/1",
                         i, InstOut, Op, Valid, exp_ir[i], exp_op[i]);
            end
        end
        tick();
        tick();
        tick();
        checks++;
        if (Done !== 1'b1 || Valid !== 1'b0 || InstAddr !== 10'd4) begin
            errors++;
            $display("FAIL seq_halt: done=%b valid=%b pc=%0d expected 1/0/4", Done, Valid, InstAddr);
        end
    endtask

    task automatic test_branch();
        fill_rom_add();
        rom[5]  = 9'h183;
        rom[6]  = 9'h0C5;
        rom[20] = 9'h045;
        do_reset();
        start_run();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (InstOut !== 9'h183 || Op !== 3'd6 || Valid !== 1'b1) begin
            errors++;
            $display("FAIL br_beq_in_ir: ir=%h op=%0d valid=%b expected 183/6/1", InstOut, Op, Valid);
        end
        BranchTaken = 1'b1;
        tick();
        BranchTaken = 1'b0;
        checks++;
        if (Valid !== 1'b0 || InstAddr !== 10'd20 || InstOut !== '0) begin
            errors++;
            $display("FAIL br_squash: valid=%b pc=%0d ir=%h expected 0/20/000", Valid, InstAddr, InstOut);
        end
        tick();
        checks++;
        if (InstOut !== 9'h045 || Valid !== 1'b1 || InstAddr !== 10'd21) begin
            errors++;
            $display("FAIL br_target: ir=%h valid=%b pc=%0d expected 045/1/21", InstOut, Valid, InstAddr);
        end

        // Not-taken BEQ, plus BranchTaken asserted while IR is not a BEQ.
        do_reset();
        start_run();
        for (int i = 0; i < 5; i++) tick();
        BranchTaken = 1'b1;
        tick();
        BranchTaken = 1'b0;
        checks++;
        if (InstOut !== 9'h183 || Valid !== 1'b1 || InstAddr !== 10'd6) begin
            errors++;
            $display("FAIL br_ignore_non_beq: ir=%h valid=%b pc=%0d expected 183/1/6", InstOut, Valid, InstAddr);
        end
        tick();
        checks++;
        if (InstOut !== 9'h0C5 || Valid !== 1'b1 || InstAddr !== 10'd7) begin
            errors++;
            $display("FAIL br_not_taken: ir=%h valid=%b pc=%0d expected 0C5/1/7", InstOut, Valid, InstAddr);
        end
    endtask

    task automatic test_stall();
        fill_rom_add();
        rom[10] = 9'h181;
        rom[11] = 9'h0AA;
        do_reset();
        start_run();
        for (int i = 0; i < 11; i++) tick();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            BranchTaken = (i == 1);
            tick();
            checks++;
            if (InstAddr !== 10'd11 || InstOut !== 9'h181 || Valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc=%0d ir=%h valid=%b expected 11/181/1",
                         i, InstAddr, InstOut, Valid);
            end
        end
        BranchTaken = 1'b0;
        Stall = 1'b0;
        tick();
        checks++;
        if (InstOut !== 9'h0AA || Valid !== 1'b1 || InstAddr !== 10'd12) begin
            errors++;
            $display("FAIL stall_resume: ir=%h valid=%b pc=%0d expected 0AA/1/12", InstOut, Valid, InstAddr);
        end
    endtask

    task automatic test_wrap_restart();
        fill_rom_add();
        do_reset();
        start_run();
        for (int i = 0; i < DEPTH; i++) tick();
        checks++;
        if (InstAddr !== '0 || InstOut !== rom[DEPTH-1] || Valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc: pc=%0d ir=%h expected 0/%h", InstAddr, InstOut, rom[DEPTH-1]);
        end
        tick();
        checks++;
        if (InstOut !== rom[0] || InstAddr !== 10'd1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_continue: ir=%h pc=%0d done=%b expected %h/1/0", InstOut, InstAddr, Done, rom[0]);
        end
        rom[5] = 9'h1FF;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (Done !== 1'b1 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_halt: done=%b valid=%b expected 1/0", Done, Valid);
        end
        start_run();
        checks++;
        if (Done !== 1'b0 || InstAddr !== '0) begin
            errors++;
            $display("FAIL restart_done: done=%b pc=%0d expected 0/0", Done, InstAddr);
        end
        tick();
        checks++;
        if (InstOut !== rom[0] || Valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_fetch: ir=%h valid=%b expected %h/1", InstOut, Valid, rom[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = INST_W'($urandom_range(0, 511));
            if (rom[i] == 9'h1FF) rom[i] = 9'h100;
        end
        for (int i = 0; i < 4; i++) rom[$urandom_range(1, 200)] = 9'h1FF;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            Start       = ($urandom_range(0, 9) == 0);
            Stall       = ($urandom_range(0, 3) == 0);
            BranchTaken = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (InstAddr !== PC_W'(m_pc) || Valid !== m_valid || Done !== m_done) begin
                errors++;
                $display("FAIL rand_state[%0d]: pc=%0d valid=%b done=%b expected %0d/%b/%b",
                         cyc, InstAddr, Valid, Done, m_pc, m_valid, m_done);
            end
            if (m_valid) begin
                checks++;
                if (InstOut !== m_ir || Op !== m_ir[8:6]) begin
                    errors++;
                    $display("FAIL rand_ir[%0d]: ir=%h op=%0d expected %h/%0d",
                             cyc, InstOut, Op, m_ir, m_ir[8:6]);
                end
            end
        end
        Start = 1'b0;
        Stall = 1'b0;
        BranchTaken = 1'b0;
    endtask

    initial begin
        lut_tgt = '{40, 64, 100, 20, 200, 512, 1000, 1023, 0, 0, 0, 0, 0, 0, 0, 0};
        Reset       = 1'b0;
        Start       = 1'b0;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        m_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode/ALU stage consuming op_mne.
- Holds the program counter, addresses the external instruction ROM, and registers the 9-bit instruction.
- Presents the registered instruction's opcode field as op_mne to downstream.
- Resolves BEQ redirects through a branch-target LUT and runs a Start/Done program handshake with the testbench/top level.

Parameters:
PC_W, 10, program counter / instruction ROM address width
INST_W, 9, instruction width; opcode is [8:6], operand field is [5:0]
LUT_W, 4, branch-target LUT index width, taken from operand bits [3:0]

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  begin program execution at PC=0
Stall  input  1  downstream hold request; freezes PC, IR and FSM
BranchTaken  input  1  downstream asserts while IR holds a valid BEQ whose compare succeeded
InstIn  input  INST_W  instruction ROM read data; combinational from InstAddr
InstAddr  output  PC_W  ROM address, equal to PC
InstOut  output  INST_W  instruction register (IR)
Op  output  3  op_mne decode of IR[8:6]
Valid  output  1  IR holds a real instruction, not a bubble
Done  output  1  program halted

Behaviour:
- Reset (async, Reset=0): FSM=IDLE, PC=0, IR=0, Valid=0, Done=0. Op therefore reads LDR (3'b000) and is qualified by Valid. Reset mid-program aborts immediately with no pending effect.
- FSM states IDLE, RUN, HALT.
- IDLE:
  - PC held at 0.
  - Start=1 -> RUN next edge; PC=0 is presented on InstAddr that cycle.
- RUN, Stall=0, no redirect, no halt:
  - IR<=InstIn, Valid<=1, PC<=PC+1.
  - Fetch latency: one cycle from InstAddr=N to InstOut=ROM[N].
- PC wrap: PC=2^PC_W-1 increments to 0 without any flag.
- Redirect: BranchTaken is sampled only when Valid=1, Op==BEQ, Stall=0.
  - PC<=branch_lut(IR[LUT_W-1:0]).
  - IR<=0, Valid<=0: the wrong-path instruction fetched that cycle is squashed.
  - Target instruction appears in IR two cycles after the BEQ was in IR.
  - BranchTaken while IR is not a valid BEQ is ignored.
- Halt:
  - IR==9'h1FF (MOV with all-ones operand) and Valid=1 -> HALT next edge.
  - Done<=1, Valid<=0, PC frozen; the instruction fetched behind it is discarded.
  - A halt word in IR is never forwarded as a second valid cycle.
- HALT:
  - Done held at 1.
  - Start=1 -> RUN with PC<=0, Done<=0. This permits back-to-back program runs.
- Stall=1, any state:
  - PC, IR, Valid, Done and FSM hold.
  - Start and BranchTaken are ignored that cycle.
  - Stall has priority over redirect and halt; downstream must hold BranchTaken until Stall drops.
- Simultaneous halt word and BranchTaken: impossible, since the halt word is not BEQ. Halt detection uses IR only.
- Start while RUN: ignored.

Decomposition:
- Definitions package:
  - Keep the existing op_mne.
  - Add fetch_state_e {IDLE, RUN, HALT}.
  - Add localparam HALT_WORD=9'h1FF.
  - Share PC_W and INST_W defaults as package constants so the ALU stage and top level agree.
- Sub-module branch_lut:
  - Combinational, parameterised LUT_W/PC_W.
  - Case statement of 2^LUT_W jump targets; unlisted indices return 0.
  - Kept separate so programs can retarget it without touching the FSM.

Test Plan:
1. Reset: Reset=0 mid-RUN with PC=37 -> same cycle PC=0, Valid=0, Done=0, FSM=IDLE. Release with Start=0 -> stays IDLE.
2. Sequential fetch: ROM[0..3]=9'h100,9'h0C5,9'h085,9'h1FF, Start pulse.
   - InstOut is 100,0C5,085 on consecutive cycles with Valid=1.
   - Op is ADD,XOR,AND.
   - Then Done=1, Valid=0, PC frozen at 4.
3. Branch: ROM[5]=BEQ idx 3 (9'h183), lut[3]=20, BranchTaken=1 while IR=9'h183.
   - Next cycle Valid=0 (ROM[6] squashed), PC=20.
   - Following cycle InstOut=ROM[20].
   - Repeat with BranchTaken=0 -> ROM[6] follows with no bubble.
4. Stall: Stall=1 for 3 cycles while IR=ROM[10] -> PC=11, InstOut, Valid unchanged. BranchTaken pulsed during stall is ignored. Release resumes with ROM[11].
5. Wrap/restart: PC_W=4, ROM full of ADD, no halt -> PC goes 15->0 and fetch continues. Then halt, pulse Start in HALT -> Done falls, InstOut=ROM[0] one cycle later.
